// File: rtl/buffer_reader_pkg.sv
// Shared widths and FSM encoding for the acquisition buffer readout path.
package buffer_reader_pkg;

  localparam int __BITS_ADC       = 8;
  localparam int __RAM_ADDR_WIDTH = 8;
  localparam int __REG_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_SEND  = 2'd3
  } br_state_t;

endpackage

// File: rtl/buffer_reader_if.sv
// Request, RAM read port and Tx byte handshake seen by one buffer reader.
interface buffer_reader_if
  import buffer_reader_pkg::*;
#(
  parameter int BITS_ADC       = __BITS_ADC,
  parameter int RAM_ADDR_WIDTH = __RAM_ADDR_WIDTH,
  parameter int REG_DATA_WIDTH = __REG_DATA_WIDTH
);
  logic                      rqst;
  logic                      stop;
  logic [REG_DATA_WIDTH-1:0] num_samples;
  logic [RAM_ADDR_WIDTH-1:0] wr_ptr;
  logic                      rd_en;
  logic [RAM_ADDR_WIDTH-1:0] rd_addr;
  logic [BITS_ADC-1:0]       rd_data;
  logic [7:0]                tx_data;
  logic                      tx_rdy;
  logic                      tx_eof;
  logic                      tx_ack;
  logic                      busy;

  modport master (
    input  rqst, stop, num_samples, wr_ptr, rd_data, tx_ack,
    output rd_en, rd_addr, tx_data, tx_rdy, tx_eof, busy
  );

  modport slave (
    output rqst, stop, num_samples, wr_ptr, rd_data, tx_ack,
    input  rd_en, rd_addr, tx_data, tx_rdy, tx_eof, busy
  );
endinterface

// File: rtl/buffer_reader_circ_addr_gen.sv
// Circular read address and remaining-sample counter for a readout.
module circ_addr_gen
  import buffer_reader_pkg::*;
#(
  parameter int AW = __RAM_ADDR_WIDTH,
  parameter int RW = __REG_DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_adv,
  input  logic          i_clr,
  input  logic [RW-1:0] i_num_samples,
  input  logic [AW-1:0] i_wr_ptr,
  output logic [AW-1:0] o_addr,
  output logic          o_last,
  output logic          o_n_zero
);
  localparam int CW = AW + 1;

  logic          w_big;
  logic [CW-1:0] w_n;
  logic [AW-1:0] w_start;
  logic [AW-1:0] r_addr;
  logic [CW-1:0] r_rem;

  // Clamp to the buffer depth before subtracting so large counts never truncate.
  assign w_big    = |(i_num_samples >> AW);
  assign w_n      = w_big ? {1'b1, {AW{1'b0}}} : {1'b0, i_num_samples[AW-1:0]};
  assign w_start  = i_wr_ptr - w_n[AW-1:0];
  assign o_n_zero = (w_n == '0);
  assign o_last   = (r_rem == CW'(1));
  assign o_addr   = r_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr <= '0;
      r_rem  <= '0;
    end else if (i_clr) begin
      r_addr <= '0;
      r_rem  <= '0;
    end else if (i_load) begin
      r_addr <= w_start;
      r_rem  <= w_n;
    end else if (i_adv) begin
      r_addr <= r_addr + AW'(1);
      r_rem  <= r_rem - CW'(1);
    end
  end

endmodule

// File: rtl/buffer_reader.sv
// Streams the newest N samples of the circular acquisition RAM to Tx, oldest first.
module buffer_reader
  import buffer_reader_pkg::*;
#(
  parameter int BITS_ADC       = __BITS_ADC,
  parameter int RAM_ADDR_WIDTH = __RAM_ADDR_WIDTH,
  parameter int REG_DATA_WIDTH = __REG_DATA_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  buffer_reader_if.master bus
);
  br_state_t                 r_state, w_state_nxt;
  logic                      r_rd_en, w_rd_en_nxt;
  logic [7:0]                r_tx_data, w_tx_data_nxt;
  logic                      r_tx_rdy, w_tx_rdy_nxt;
  logic                      r_tx_eof, w_tx_eof_nxt;
  logic                      r_busy, w_busy_nxt;
  logic                      w_load, w_adv;
  logic                      w_last, w_n_zero;
  logic [RAM_ADDR_WIDTH-1:0] w_addr;

  circ_addr_gen #(.AW(RAM_ADDR_WIDTH), .RW(REG_DATA_WIDTH)) u_addr (
    .clk           (clk),
    .rst           (rst),
    .i_load        (w_load),
    .i_adv         (w_adv),
    .i_clr         (bus.stop),
    .i_num_samples (bus.num_samples),
    .i_wr_ptr      (bus.wr_ptr),
    .o_addr        (w_addr),
    .o_last        (w_last),
    .o_n_zero      (w_n_zero)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_rd_en_nxt   = 1'b0;
    w_tx_data_nxt = r_tx_data;
    w_tx_rdy_nxt  = r_tx_rdy;
    w_tx_eof_nxt  = r_tx_eof;
    w_busy_nxt    = r_busy;
    w_load        = 1'b0;
    w_adv         = 1'b0;
    // Abort beats everything, including a same-cycle ack or request.
    if (bus.stop) begin
      w_state_nxt   = ST_IDLE;
      w_tx_data_nxt = '0;
      w_tx_rdy_nxt  = 1'b0;
      w_tx_eof_nxt  = 1'b0;
      w_busy_nxt    = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.rqst && !w_n_zero) begin
          w_load      = 1'b1;
          w_busy_nxt  = 1'b1;
          w_rd_en_nxt = 1'b1;
          w_state_nxt = ST_FETCH;
        end
        ST_FETCH: w_state_nxt = ST_WAIT;
        ST_WAIT: begin
          w_tx_data_nxt = 8'(bus.rd_data);
          w_tx_rdy_nxt  = 1'b1;
          w_tx_eof_nxt  = w_last;
          w_state_nxt   = ST_SEND;
        end
        ST_SEND: if (bus.tx_ack) begin
          w_adv        = 1'b1;
          w_tx_rdy_nxt = 1'b0;
          w_tx_eof_nxt = 1'b0;
          if (w_last) begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_rd_en_nxt = 1'b1;
            w_state_nxt = ST_FETCH;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_rd_en   <= 1'b0;
      r_tx_data <= '0;
      r_tx_rdy  <= 1'b0;
      r_tx_eof  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_en   <= w_rd_en_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_tx_rdy  <= w_tx_rdy_nxt;
      r_tx_eof  <= w_tx_eof_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign bus.rd_en   = r_rd_en;
  assign bus.rd_addr = w_addr;
  assign bus.tx_data = r_tx_data;
  assign bus.tx_rdy  = r_tx_rdy;
  assign bus.tx_eof  = r_tx_eof;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_buffer_reader.sv
// Directed bench: RAM model feeds the reader, a queue holds the expected byte stream.
module tb_buffer_reader;

  typedef struct {
    logic [7:0] d;
    logic       eof;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   rd_cnt = 0;
  logic [7:0] ram [256];
  exp_t sb [$];

  buffer_reader_if #(.BITS_ADC(8), .RAM_ADDR_WIDTH(8), .REG_DATA_WIDTH(16)) bus ();

  buffer_reader dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.rd_data <= ram[bus.rd_addr];
      rd_cnt      <= rd_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < 256; i++) ram[i] = (mode == 0) ? 8'(i) : ~8'(i);
  endtask

  task automatic push_readout(input int ns, input int wp);
    int n;
    logic [7:0] s;
    n = (ns > 256) ? 256 : ns;
    s = 8'(wp - n);
    for (int i = 0; i < n; i++) sb.push_back('{ram[8'(s + 8'(i))], (i == n - 1)});
  endtask

  task automatic pulse_rqst(input int ns, input int wp);
    bus.num_samples = 16'(ns);
    bus.wr_ptr      = 8'(wp);
    bus.rqst        = 1'b1;
    tick();
    bus.rqst        = 1'b0;
  endtask

  task automatic wait_rdy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.tx_rdy) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic recv(input int hold);
    bit ok;
    exp_t e;
    int n;
    logic [7:0] d;
    wait_rdy(ok);
    if (!ok) begin
      chk("rdy_timeout", 32'(ok), 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      chk("unexpected_byte", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk("tx_data", bus.tx_data, e.d);
    chk("tx_eof", bus.tx_eof, e.eof);
    n = rd_cnt;
    d = bus.tx_data;
    if (hold > 0) begin
      repeat (hold) begin
        tick();
        chk("hold_rdy", bus.tx_rdy, 1);
        chk("hold_data", bus.tx_data, d);
      end
      chk("hold_no_rd", rd_cnt, n);
    end
    bus.tx_ack = 1'b1;
    tick();
    bus.tx_ack = 1'b0;
    chk("rdy_after_ack", bus.tx_rdy, 0);
  endtask

  initial begin
    bit ok;
    int n0;
    bus.rqst = 1'b0;
    bus.stop = 1'b0;
    bus.tx_ack = 1'b0;
    bus.num_samples = '0;
    bus.wr_ptr = '0;
    bus.rd_data = '0;
    fill(0);
    tick();
    tick();
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_tx_rdy", bus.tx_rdy, 0);
    chk("rst_tx_eof", bus.tx_eof, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b1;
    tick();

    // basic readout with latency checks
    n0 = rd_cnt;
    push_readout(5, 20);
    pulse_rqst(5, 20);
    chk("t1_rd_en", bus.rd_en, 1);
    chk("t1_busy", bus.busy, 1);
    chk("t1_addr", bus.rd_addr, 15);
    chk("t1_rdy_early", bus.tx_rdy, 0);
    tick();
    chk("t1_rd_en_drop", bus.rd_en, 0);
    chk("t1_rdy_wait", bus.tx_rdy, 0);
    tick();
    chk("t1_rdy_k3", bus.tx_rdy, 1);
    repeat (5) recv(0);
    chk("t1_busy_end", bus.busy, 0);
    chk("t1_rd_cnt", rd_cnt - n0, 5);

    // wrap-around
    fill(1);
    push_readout(4, 2);
    pulse_rqst(4, 2);
    chk("t2_addr0", bus.rd_addr, 254);
    repeat (4) recv(0);
    chk("t2_busy_end", bus.busy, 0);

    // backpressure on byte 2 of 3, with a stray ack before it
    fill(0);
    push_readout(3, 50);
    pulse_rqst(3, 50);
    recv(0);
    chk("t3_stray_rdy", bus.tx_rdy, 0);
    bus.tx_ack = 1'b1;
    tick();
    bus.tx_ack = 1'b0;
    recv(10);
    recv(0);
    chk("t3_busy_end", bus.busy, 0);

    // zero samples, then stop+rqst while idle
    n0 = rd_cnt;
    pulse_rqst(0, 40);
    for (int i = 0; i < 5; i++) begin
      chk("t4_n0_busy", bus.busy, 0);
      chk("t4_n0_rdy", bus.tx_rdy, 0);
      tick();
    end
    bus.stop = 1'b1;
    pulse_rqst(5, 40);
    bus.stop = 1'b0;
    chk("t4_stop_rqst_busy", bus.busy, 0);
    tick();
    chk("t4_no_rd", rd_cnt, n0);

    // oversize request clamps to full depth
    push_readout(1000, 77);
    pulse_rqst(1000, 77);
    chk("t4_big_addr", bus.rd_addr, 77);
    repeat (256) recv(0);
    chk("t4_big_busy", bus.busy, 0);
    chk("t4_big_sb", sb.size(), 0);

    // abort during byte 3 of 10 with a simultaneous ack
    push_readout(10, 60);
    pulse_rqst(10, 60);
    recv(0);
    recv(0);
    wait_rdy(ok);
    chk("t5_rdy3", 32'(ok), 1);
    bus.stop = 1'b1;
    bus.tx_ack = 1'b1;
    tick();
    bus.stop = 1'b0;
    bus.tx_ack = 1'b0;
    chk("t5_rdy", bus.tx_rdy, 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_eof", bus.tx_eof, 0);
    chk("t5_addr", bus.rd_addr, 0);
    chk("t5_data", bus.tx_data, 0);
    sb.delete();
    n0 = rd_cnt;
    repeat (4) tick();
    chk("t5_idle_no_rd", rd_cnt, n0);
    chk("t5_idle_rdy", bus.tx_rdy, 0);
    push_readout(3, 100);
    pulse_rqst(3, 100);
    chk("t5_restart_addr", bus.rd_addr, 97);
    repeat (3) recv(0);

    // async reset during WAIT
    pulse_rqst(4, 30);
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_rd_en", bus.rd_en, 0);
    chk("t6_rst_addr", bus.rd_addr, 0);
    chk("t6_rst_rdy", bus.tx_rdy, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_data", bus.tx_data, 0);
    tick();
    rst = 1'b1;
    tick();

    // rqst while busy is ignored
    push_readout(4, 30);
    pulse_rqst(4, 30);
    recv(0);
    pulse_rqst(2, 200);
    repeat (3) recv(0);
    chk("t6_busy_end", bus.busy, 0);
    for (int i = 0; i < 8; i++) begin
      chk("t6_no_extra", bus.tx_rdy, 0);
      tick();
    end
    chk("t6_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/buffer_reader.md
Name: buffer_reader

Overview:
Read-side counterpart of the trigger block's capture path. The trigger block writes ADC samples into the circular acquisition RAM with `we`. This block reads the last `num_samples` samples back in chronological order, oldest first, and streams them byte by byte to the Tx protocol using the rdy/ack/eof handshake. It sits between the request handler, the RAM controller's read port and the Tx arbiter, with one instance per channel buffer.

Parameters:
BITS_ADC, 8, sample width; must be ≤8; samples are zero-extended onto tx_data.
RAM_ADDR_WIDTH, 8, circular buffer address width; depth = 2^RAM_ADDR_WIDTH.
REG_DATA_WIDTH, 16, width of the num_samples register value.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
rqst  in  1  one-cycle pulse from the request handler: start readout
stop  in  1  one-cycle pulse: abort readout
num_samples  in  REG_DATA_WIDTH  number of samples to send (from the trigger block)
wr_ptr  in  RAM_ADDR_WIDTH  next address the writer would use; stable while busy
rd_en  out  1  RAM read strobe
rd_addr  out  RAM_ADDR_WIDTH  RAM read address
rd_data  in  BITS_ADC  RAM read data, valid the cycle after rd_en
tx_data  out  8  sample byte to the Tx protocol
tx_rdy  out  1  tx_data valid
tx_eof  out  1  marks the last byte; qualified by tx_rdy
tx_ack  in  1  Tx consumed the byte
busy  out  1  readout in progress (used by the RAM arbiter)

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; rd_en=0, rd_addr=0, tx_data=0, tx_rdy=0, tx_eof=0, busy=0; internal counter=0. All outputs are registered.
- Effective count N = min(num_samples, 2^RAM_ADDR_WIDTH), latched on rqst.
- Start address = (wr_ptr − N) mod 2^RAM_ADDR_WIDTH, latched on rqst.
- Address arithmetic is modulo the buffer depth; rd_addr wraps from depth−1 to 0.
- FSM states: IDLE, FETCH, WAIT, SEND.
- IDLE:
  - rqst with N>0 → FETCH; busy=1, rd_addr=start, remaining=N.
  - rqst with N=0 → stay in IDLE; no output activity.
- FETCH (one cycle): rd_en=1 → WAIT.
- WAIT (one cycle): rd_en=0; rd_data is valid now.
  - At the closing edge: tx_data={0, rd_data}, tx_rdy=1, tx_eof=(remaining==1) → SEND.
- SEND: tx_rdy and tx_data are held stable until tx_ack=1 is sampled.
  - On ack: tx_rdy=0, tx_eof=0, remaining−1, rd_addr+1.
  - Then → FETCH if remaining (before decrement) >1, else → IDLE with busy=0.
- Timing: rqst sampled at edge k → rd_en high during cycle k+1 → tx_rdy high from cycle k+3. Each further byte takes 3 cycles minimum (ack in the first rdy cycle).
- tx_ack while tx_rdy=0 is ignored.
- rqst while busy is ignored; the latched N and start address do not change.
- stop in any state: → IDLE at the next edge with all outputs forced to their reset values. No eof is emitted.
- stop and tx_ack in the same cycle: stop wins; the byte counts as not delivered.
- stop and rqst in the same cycle while IDLE: stop wins; the block stays in IDLE.
- Only the last byte of a readout carries eof; N=1 gives a single byte with eof.
- num_samples wider than the counter: the clamp is applied before the subtraction, so there is no truncation.

Decomposition:
- Shared defines package gets:
  - `__RAM_ADDR_WIDTH`, next to the existing `__BITS_ADC` and `__REG_DATA_WIDTH`.
  - FSM state encodings: IDLE=0, FETCH=1, WAIT=2, SEND=3.
- One natural sub-module: circ_addr_gen. It holds the start-address computation, the modulo increment and the remaining-sample counter, and exposes `last` and `addr`. The FSM and the Tx handshake stay in buffer_reader.

Test Plan:
1. Basic readout: wr_ptr=20, num_samples=5, RAM[i]=i, rqst → bytes 15,16,17,18,19 with eof only on 19; busy drops the cycle after the last ack.
2. Wrap-around: RAM_ADDR_WIDTH=8, wr_ptr=2, num_samples=4 → addresses 254,255,0,1 read in that order; data matches RAM contents.
3. Backpressure: ack withheld for 10 cycles on byte 2 of 3 → tx_rdy and tx_data stay stable all 10 cycles; the ack without rdy is ignored; no rd_en pulse occurs until the ack.
4. Boundaries:
   - num_samples=0 → no rd_en, no tx_rdy, busy stays 0.
   - num_samples=1000 with depth 256 → exactly 256 bytes starting at wr_ptr; eof on the 256th.
5. Abort: stop during SEND of byte 3 of 10 → IDLE next cycle, tx_rdy=0, busy=0, no eof. A following rqst restarts from the freshly computed start address.
6. Reset mid-operation and rqst while busy:
   - rst low during WAIT → all outputs 0 immediately (asynchronously).
   - After release, a rqst pulse while busy is ignored: total bytes still equal the original N.
